// File: rtl/itch_order_store_pkg.sv
// Shared types for the ITCH order-reference table: stored entry layout,
// the level-update bundle and the internal opcode.
package itch_order_store_pkg;

  localparam logic BUY  = 1'b1;
  localparam logic SELL = 1'b0;

  typedef struct packed {
    logic [63:0] tag;
    logic [15:0] locate;
    logic [31:0] price;
    logic [31:0] shares;
    logic        buySell;
  } orderEntryType;

  typedef struct packed {
    logic [15:0] locate;
    logic [31:0] price;
    logic [31:0] shares;
    logic        inc;
    logic        buySell;
  } bookUpdateType;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_DEL,
    OP_EXEC
  } op_e;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/itch_order_store_ram.sv
// Simple dual-port RAM, one write and one registered read port.
// Read-during-write to the same address returns the old word.
module order_ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/itch_order_store.sv
// Direct-mapped order-reference table: turns parser add/delete/execute
// strobes into registered price-level updates (2-edge latency, 1 msg/cycle).
module itch_order_store
  import itch_order_store_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic        clkIn,
  input  logic        rstNIn,
  input  logic        addValidIn,
  input  logic        delValidIn,
  input  logic        execValidIn,
  input  logic [63:0] refNumIn,
  input  logic [15:0] locateIn,
  input  logic [31:0] priceIn,
  input  logic [31:0] sharesIn,
  input  logic        buySellIn,
  output logic        updValidOut,
  output logic [15:0] updLocateOut,
  output logic [31:0] updPriceOut,
  output logic [31:0] updSharesOut,
  output logic        updIncOut,
  output logic        updBuySellOut,
  output logic        missOut,
  output logic        collisionOut,
  output logic        multiOut
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int EW    = $bits(orderEntryType);

  logic [IDX_W-1:0] idx0;
  op_e              op0;
  logic             multi0;

  op_e              s1_op_reg;
  logic             s1_multi_reg;
  logic [IDX_W-1:0] s1_idx_reg;
  logic [63:0]      s1_ref_reg;
  logic [15:0]      s1_locate_reg;
  logic [31:0]      s1_price_reg;
  logic [31:0]      s1_shares_reg;
  logic             s1_buysell_reg;
  logic             fwd_hit_reg;
  orderEntryType    fwd_data_reg;

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [EW-1:0]    ram_rdata;
  logic             ram_we;
  orderEntryType    ram_wdata;
  orderEntryType    stored;
  logic             slot_valid;
  logic             hit;
  logic             valid_set;
  logic             valid_clr;
  logic             upd_v_next;
  bookUpdateType    upd_next;
  logic             miss_next;
  logic             coll_next;

  assign idx0   = refNumIn[IDX_W-1:0] ^ refNumIn[2*IDX_W-1:IDX_W];
  assign multi0 = (addValidIn & delValidIn) | (addValidIn & execValidIn) | (delValidIn & execValidIn);

  always_comb begin
    op0 = OP_NONE;
    if (addValidIn)       op0 = OP_ADD;
    else if (delValidIn)  op0 = OP_DEL;
    else if (execValidIn) op0 = OP_EXEC;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      s1_op_reg    <= OP_NONE;
      s1_multi_reg <= 1'b0;
    end else begin
      s1_op_reg    <= op0;
      s1_multi_reg <= multi0;
    end
  end

  // RAM read issued this cycle misses a write landing on the same edge,
  // so capture that write word and substitute it in S1.
  always_ff @(posedge clkIn) begin
    s1_idx_reg     <= idx0;
    s1_ref_reg     <= refNumIn;
    s1_locate_reg  <= locateIn;
    s1_price_reg   <= priceIn;
    s1_shares_reg  <= sharesIn;
    s1_buysell_reg <= buySellIn;
    fwd_hit_reg    <= ram_we && (s1_idx_reg == idx0);
    fwd_data_reg   <= ram_wdata;
  end

  order_ram #(.AW(IDX_W), .DW(EW)) u_ram (
    .clk   (clkIn),
    .we    (ram_we),
    .waddr (s1_idx_reg),
    .wdata (ram_wdata),
    .raddr (idx0),
    .rdata (ram_rdata)
  );

  assign stored     = fwd_hit_reg ? fwd_data_reg : orderEntryType'(ram_rdata);
  assign slot_valid = valid_reg[s1_idx_reg];
  assign hit        = slot_valid && (stored.tag == s1_ref_reg);

  always_comb begin
    ram_we             = 1'b0;
    ram_wdata          = stored;
    valid_set          = 1'b0;
    valid_clr          = 1'b0;
    upd_v_next         = 1'b0;
    upd_next.locate    = stored.locate;
    upd_next.price     = stored.price;
    upd_next.shares    = stored.shares;
    upd_next.inc       = 1'b0;
    upd_next.buySell   = stored.buySell;
    miss_next          = 1'b0;
    coll_next          = 1'b0;
    case (s1_op_reg)
      OP_ADD: begin
        if (!slot_valid || (stored.tag == s1_ref_reg)) begin
          ram_we           = 1'b1;
          ram_wdata.tag    = s1_ref_reg;
          ram_wdata.locate = s1_locate_reg;
          ram_wdata.price  = s1_price_reg;
          ram_wdata.shares = s1_shares_reg;
          ram_wdata.buySell = s1_buysell_reg;
          valid_set        = 1'b1;
          upd_v_next       = 1'b1;
          upd_next.locate  = s1_locate_reg;
          upd_next.price   = s1_price_reg;
          upd_next.shares  = s1_shares_reg;
          upd_next.inc     = 1'b1;
          upd_next.buySell = s1_buysell_reg;
        end else begin
          coll_next = 1'b1;
        end
      end
      OP_DEL: begin
        if (hit) begin
          valid_clr  = 1'b1;
          upd_v_next = 1'b1;
        end else begin
          miss_next = 1'b1;
        end
      end
      OP_EXEC: begin
        if (hit) begin
          upd_v_next      = 1'b1;
          upd_next.shares = min_u32(s1_shares_reg, stored.shares);
          if (s1_shares_reg >= stored.shares) begin
            valid_clr = 1'b1;
          end else begin
            ram_we           = 1'b1;
            ram_wdata.shares = stored.shares - s1_shares_reg;
          end
        end else begin
          miss_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    assign valid_next[gi] = (valid_set && s1_idx_reg == IDX_W'(gi)) ? 1'b1 :
                            (valid_clr && s1_idx_reg == IDX_W'(gi)) ? 1'b0 : valid_reg[gi];
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) valid_reg <= '0;
    else         valid_reg <= valid_next;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      updValidOut   <= 1'b0;
      updLocateOut  <= '0;
      updPriceOut   <= '0;
      updSharesOut  <= '0;
      updIncOut     <= 1'b0;
      updBuySellOut <= 1'b0;
      missOut       <= 1'b0;
      collisionOut  <= 1'b0;
      multiOut      <= 1'b0;
    end else begin
      updValidOut  <= upd_v_next;
      missOut      <= miss_next;
      collisionOut <= coll_next;
      multiOut     <= s1_multi_reg;
      if (upd_v_next) begin
        updLocateOut  <= upd_next.locate;
        updPriceOut   <= upd_next.price;
        updSharesOut  <= upd_next.shares;
        updIncOut     <= upd_next.inc;
        updBuySellOut <= upd_next.buySell;
      end
    end
  end

endmodule

// File: tb/tb_itch_order_store.sv
// Directed bench for itch_order_store: hand-computed level updates,
// miss/collision/multi pulses, forwarding and asynchronous reset.
module tb_itch_order_store;
  import itch_order_store_pkg::*;

  logic        clkIn = 1'b0;
  logic        rstNIn;
  logic        addValidIn, delValidIn, execValidIn;
  logic [63:0] refNumIn;
  logic [15:0] locateIn;
  logic [31:0] priceIn, sharesIn;
  logic        buySellIn;
  logic        updValidOut, updIncOut, updBuySellOut;
  logic [15:0] updLocateOut;
  logic [31:0] updPriceOut, updSharesOut;
  logic        missOut, collisionOut, multiOut;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] REF_A = 64'hDEFB1673DEFB1673;
  localparam logic [63:0] REF_B = 64'hDEFB1672DEFB1673;  // same index, other tag
  localparam logic [63:0] REF_C = 64'h0000000000001234;
  localparam logic [63:0] REF_D = 64'h0000000000000ABC;
  localparam logic [63:0] REF_E = 64'h0000000000000055;
  localparam logic [63:0] REF_F = 64'h0000000000000777;
  localparam logic [63:0] REF_G = 64'h9999000000000100;
  localparam logic [63:0] REF_H = 64'h0000000000000200;

  itch_order_store #(.IDX_W(10)) dut (
    .clkIn(clkIn), .rstNIn(rstNIn),
    .addValidIn(addValidIn), .delValidIn(delValidIn), .execValidIn(execValidIn),
    .refNumIn(refNumIn), .locateIn(locateIn), .priceIn(priceIn),
    .sharesIn(sharesIn), .buySellIn(buySellIn),
    .updValidOut(updValidOut), .updLocateOut(updLocateOut), .updPriceOut(updPriceOut),
    .updSharesOut(updSharesOut), .updIncOut(updIncOut), .updBuySellOut(updBuySellOut),
    .missOut(missOut), .collisionOut(collisionOut), .multiOut(multiOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic drive(input logic a, input logic d, input logic e, input logic [63:0] r,
                       input logic [15:0] l, input logic [31:0] p, input logic [31:0] s,
                       input logic bs);
    @(negedge clkIn);
    addValidIn = a; delValidIn = d; execValidIn = e;
    refNumIn = r; locateIn = l; priceIn = p; sharesIn = s; buySellIn = bs;
  endtask

  task automatic idle();
    @(negedge clkIn);
    addValidIn = 1'b0; delValidIn = 1'b0; execValidIn = 1'b0;
  endtask

  // Single message, then wait until its result is visible.
  task automatic op(input logic a, input logic d, input logic e, input logic [63:0] r,
                    input logic [15:0] l, input logic [31:0] p, input logic [31:0] s,
                    input logic bs);
    drive(a, d, e, r, l, p, s, bs);
    idle();
    @(negedge clkIn);
  endtask

  // Data fields are only compared when an update is expected.
  task automatic check(input string tag, input logic v, input logic inc, input logic [15:0] l,
                       input logic [31:0] p, input logic [31:0] s, input logic bs,
                       input logic miss, input logic coll, input logic multi);
    logic [85:0] obs, exp;
    obs = {updValidOut, missOut, collisionOut, multiOut,
           v ? {updLocateOut, updPriceOut, updSharesOut, updIncOut, updBuySellOut} : 82'b0};
    exp = {v, miss, coll, multi, v ? {l, p, s, inc, bs} : 82'b0};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
    $display("txn %s: valid=%b inc=%b loc=%h price=%h shares=%0d side=%b miss=%b coll=%b multi=%b",
             tag, updValidOut, updIncOut, updLocateOut, updPriceOut, updSharesOut,
             updBuySellOut, missOut, collisionOut, multiOut);
  endtask

  task automatic check_zero(input string tag);
    logic [85:0] obs;
    obs = {updValidOut, missOut, collisionOut, multiOut,
           updLocateOut, updPriceOut, updSharesOut, updIncOut, updBuySellOut};
    vectors++;
    assert (obs === 86'b0) else begin
      miscompares++;
      $error("FAIL %s: observed %h required all-zero", tag, obs);
    end
    $display("txn %s: outputs=%h", tag, obs);
  endtask

  initial begin
    rstNIn = 1'b0;
    addValidIn = 1'b0; delValidIn = 1'b0; execValidIn = 1'b0;
    refNumIn = '0; locateIn = '0; priceIn = '0; sharesIn = '0; buySellIn = 1'b0;
    repeat (3) @(negedge clkIn);
    check_zero("reset_state");
    rstNIn = 1'b1;

    // Add then delete
    op(1, 0, 0, REF_A, 16'hBE42, 32'h0022FEFC, 32'd45, BUY);
    check("add_a", 1, 1, 16'hBE42, 32'h0022FEFC, 32'd45, BUY, 0, 0, 0);
    op(0, 1, 0, REF_A, 16'h0, 32'h0, 32'd0, SELL);
    check("del_a", 1, 0, 16'hBE42, 32'h0022FEFC, 32'd45, BUY, 0, 0, 0);
    op(0, 1, 0, REF_A, 16'h0, 32'h0, 32'd0, SELL);
    check("del_a_again_miss", 0, 0, 16'h0, 32'h0, 32'd0, 0, 1, 0, 0);

    // Partial then full execute
    op(1, 0, 0, REF_C, 16'h0007, 32'h00010000, 32'd100, SELL);
    check("add_c", 1, 1, 16'h0007, 32'h00010000, 32'd100, SELL, 0, 0, 0);
    op(0, 0, 1, REF_C, 16'h0, 32'h0, 32'd30, BUY);
    check("exec_c_30", 1, 0, 16'h0007, 32'h00010000, 32'd30, SELL, 0, 0, 0);
    op(0, 0, 1, REF_C, 16'h0, 32'h0, 32'd100, BUY);
    check("exec_c_clamp_70", 1, 0, 16'h0007, 32'h00010000, 32'd70, SELL, 0, 0, 0);
    op(0, 0, 1, REF_C, 16'h0, 32'h0, 32'd5, BUY);
    check("exec_c_miss", 0, 0, 16'h0, 32'h0, 32'd0, 0, 1, 0, 0);

    // Collision
    op(1, 0, 0, REF_A, 16'hBE42, 32'h0022FEFC, 32'd45, BUY);
    check("add_a2", 1, 1, 16'hBE42, 32'h0022FEFC, 32'd45, BUY, 0, 0, 0);
    op(1, 0, 0, REF_B, 16'h0001, 32'h00000100, 32'd99, SELL);
    check("add_b_collision", 0, 0, 16'h0, 32'h0, 32'd0, 0, 0, 1, 0);
    op(0, 1, 0, REF_A, 16'h0, 32'h0, 32'd0, SELL);
    check("del_a_after_coll", 1, 0, 16'hBE42, 32'h0022FEFC, 32'd45, BUY, 0, 0, 0);

    // Back-to-back add -> delete
    drive(1, 0, 0, REF_D, 16'h0ABC, 32'h00001000, 32'd12, BUY);
    drive(0, 1, 0, REF_D, 16'h0, 32'h0, 32'd0, SELL);
    idle();
    check("b2b_add_d", 1, 1, 16'h0ABC, 32'h00001000, 32'd12, BUY, 0, 0, 0);
    @(negedge clkIn);
    check("b2b_del_d", 1, 0, 16'h0ABC, 32'h00001000, 32'd12, BUY, 0, 0, 0);
    op(0, 1, 0, REF_D, 16'h0, 32'h0, 32'd0, SELL);
    check("del_d_miss", 0, 0, 16'h0, 32'h0, 32'd0, 0, 1, 0, 0);

    // Back-to-back exec -> exec
    op(1, 0, 0, REF_E, 16'h0055, 32'h00002000, 32'd50, SELL);
    check("add_e", 1, 1, 16'h0055, 32'h00002000, 32'd50, SELL, 0, 0, 0);
    drive(0, 0, 1, REF_E, 16'h0, 32'h0, 32'd10, BUY);
    drive(0, 0, 1, REF_E, 16'h0, 32'h0, 32'd10, BUY);
    idle();
    check("b2b_exec_e_1", 1, 0, 16'h0055, 32'h00002000, 32'd10, SELL, 0, 0, 0);
    @(negedge clkIn);
    check("b2b_exec_e_2", 1, 0, 16'h0055, 32'h00002000, 32'd10, SELL, 0, 0, 0);
    op(0, 0, 1, REF_E, 16'h0, 32'h0, 32'd30, BUY);
    check("exec_e_exact_30", 1, 0, 16'h0055, 32'h00002000, 32'd30, SELL, 0, 0, 0);
    op(0, 0, 1, REF_E, 16'h0, 32'h0, 32'd1, BUY);
    check("exec_e_miss", 0, 0, 16'h0, 32'h0, 32'd0, 0, 1, 0, 0);

    // Simultaneous add + delete: add wins
    drive(1, 1, 0, REF_F, 16'h0042, 32'h00000500, 32'd7, BUY);
    idle();
    @(negedge clkIn);
    check("multi_add_f", 1, 1, 16'h0042, 32'h00000500, 32'd7, BUY, 0, 0, 1);
    @(negedge clkIn);
    check("multi_once", 0, 0, 16'h0, 32'h0, 32'd0, 0, 0, 0, 0);
    op(0, 1, 0, REF_F, 16'h0, 32'h0, 32'd0, SELL);
    check("del_f", 1, 0, 16'h0042, 32'h00000500, 32'd7, BUY, 0, 0, 0);

    // Reset mid-stream with H in flight
    drive(1, 0, 0, REF_G, 16'h1111, 32'h00002222, 32'd9, SELL);
    drive(1, 0, 0, REF_H, 16'h2222, 32'h00003333, 32'd8, BUY);
    idle();
    check("add_g", 1, 1, 16'h1111, 32'h00002222, 32'd9, SELL, 0, 0, 0);
    #1 rstNIn = 1'b0;
    #1 check_zero("async_reset");
    repeat (2) @(negedge clkIn);
    rstNIn = 1'b1;
    op(0, 1, 0, REF_G, 16'h0, 32'h0, 32'd0, SELL);
    check("del_g_after_reset", 0, 0, 16'h0, 32'h0, 32'd0, 0, 1, 0, 0);
    op(0, 1, 0, REF_H, 16'h0, 32'h0, 32'd0, SELL);
    check("del_h_after_reset", 0, 0, 16'h0, 32'h0, 32'd0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
